// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x oversample tick; LSB-first, optional parity.
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | qualifying start bit at its midpoint
// DATA   | sampling DBIT data bits at bit centres
// PARITY | sampling parity bit, latching mismatch
// STOP   | sampling final stop bit, publishing frame
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    localparam int            NW       = $clog2(DBIT);
    localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_ONE    = NW'(1);
    localparam logic [4:0]    S_MID    = 5'(MID_START);
    localparam logic [4:0]    S_LAST   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    S_STOP   = 5'(SB_TICK - 1);
    localparam logic          PAR_EN   = (PARITY_EN != 0);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    rx_state_t       state;
    logic            rx_s;
    logic [4:0]      s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] b_reg;
    logic            p_bad;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            b_reg        <= '0;
            p_bad        <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                // Start detection is the only transition not gated by s_tick.
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt == S_MID) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt <= '0;
                            b_reg <= {rx_s, b_reg[DBIT-1:1]};
                            if (n_cnt == LAST_BIT) begin
                                state <= PAR_EN ? PARITY : STOP;
                            end else begin
                                n_cnt <= n_cnt + N_ONE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt <= '0;
                            p_bad <= rx_s ^ (^b_reg) ^ PAR_ODD;
                            state <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt == S_STOP) begin
                            dout         <= b_reg;
                            frame_err    <= ~rx_s;
                            parity_err   <= PAR_EN & p_bad;
                            rx_done_tick <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench: an 8N1 receiver and an 8E1 receiver on separate lines.
module tb_uart_rx_oversampled;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout_n, dout_p;
    logic       done_n, done_p, pe_n, pe_p, fe_n, fe_p;

    int   total = 0;
    int   bad = 0;
    bit   tick_tie = 1'b0;
    int   tcnt = 0;
    int   run_n = 0;
    int   run_p = 0;
    int   long_pulse = 0;
    rec_t q_n[$];
    rec_t q_p[$];

    always #5 clk = ~clk;

    // Baud generator model: one tick every 10 clk, or every clk when tied high.
    always @(negedge clk) begin
        if (tick_tie) begin
            s_tick = 1'b1;
        end else begin
            tcnt   = (tcnt == 9) ? 0 : tcnt + 1;
            s_tick = (tcnt == 0);
        end
    end

    always @(negedge clk) begin
        if (done_n === 1'b1) q_n.push_back({dout_n, pe_n, fe_n});
        if (done_p === 1'b1) q_p.push_back({dout_p, pe_p, fe_p});
        run_n = (done_n === 1'b1) ? run_n + 1 : 0;
        run_p = (done_p === 1'b1) ? run_p + 1 : 0;
        if (run_n > 1 || run_p > 1) long_pulse++;
    end

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .dout(dout_n), .rx_done_tick(done_n), .parity_err(pe_n), .frame_err(fe_n)
    );

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .reset(reset), .rx(rx_p), .s_tick(s_tick),
        .dout(dout_p), .rx_done_tick(done_p), .parity_err(pe_p), .frame_err(fe_p)
    );

    task automatic send_bit(input bit sel, input logic v, input int n);
        #1;
        if (sel) rx_p = v;
        else     rx   = v;
        repeat (n) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par,
                              input logic pbit, input logic stop, input int stop_ticks);
        send_bit(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], 16);
        if (par) send_bit(sel, pbit, 16);
        send_bit(sel, stop, stop_ticks);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (dout_n !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout_n); end
        total++; if (done_n !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done_n); end
        total++; if ({pe_n, fe_n} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {pe_n, fe_n}); end
        total++; if ({dout_p, done_p, pe_p, fe_p} !== 11'h0) begin bad++; $display("FAIL reset_par_dut got=%h exp=0", {dout_p, done_p, pe_p, fe_p}); end
        reset = 1'b0;
        send_bit(0, 1'b1, 20);
        total++; if (q_n.size() + q_p.size() !== 0) begin bad++; $display("FAIL reset_idle_done got=%0d exp=0", q_n.size() + q_p.size()); end
    endtask

    task automatic test_basic();
        rec_t r;
        q_n.delete();
        send_frame(0, 8'h55, 0, 1'b0, 1'b1, 16);
        send_bit(0, 1'b1, 20);
        total++; if (q_n.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", q_n.size()); end
        r = (q_n.size() > 0) ? q_n.pop_front() : 'x;
        total++; if (r !== {8'h55, 1'b0, 1'b0}) begin bad++; $display("FAIL basic_frame got=%h exp=%h", r, {8'h55, 2'b00}); end
    endtask

    task automatic test_false_start();
        q_n.delete();
        send_bit(0, 1'b0, 4);
        send_bit(0, 1'b1, 40);
        total++; if (q_n.size() !== 0) begin bad++; $display("FAIL false_start_done got=%0d exp=0", q_n.size()); end
        total++; if (dout_n !== 8'h55) begin bad++; $display("FAIL false_start_dout got=%h exp=55", dout_n); end
    endtask

    task automatic test_frame_err();
        rec_t r;
        q_n.delete();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b0, 12);
        send_bit(0, 1'b1, 40);
        total++; if (q_n.size() !== 1) begin bad++; $display("FAIL frame_err_count got=%0d exp=1", q_n.size()); end
        r = (q_n.size() > 0) ? q_n.pop_front() : 'x;
        total++; if (r !== {8'hA5, 1'b0, 1'b1}) begin bad++; $display("FAIL frame_err_frame got=%h exp=%h", r, {8'hA5, 2'b01}); end
    endtask

    task automatic test_parity();
        rec_t r;
        q_p.delete();
        send_frame(1, 8'hA3, 1, 1'b0, 1'b1, 16);
        send_bit(1, 1'b1, 20);
        send_frame(1, 8'hA3, 1, 1'b1, 1'b1, 16);
        send_bit(1, 1'b1, 20);
        total++; if (q_p.size() !== 2) begin bad++; $display("FAIL parity_count got=%0d exp=2", q_p.size()); end
        r = (q_p.size() > 0) ? q_p.pop_front() : 'x;
        total++; if (r !== {8'hA3, 1'b0, 1'b0}) begin bad++; $display("FAIL parity_good got=%h exp=%h", r, {8'hA3, 2'b00}); end
        r = (q_p.size() > 0) ? q_p.pop_front() : 'x;
        total++; if (r !== {8'hA3, 1'b1, 1'b0}) begin bad++; $display("FAIL parity_bad got=%h exp=%h", r, {8'hA3, 2'b10}); end
    endtask

    task automatic test_reset_mid_frame();
        rec_t r;
        logic [7:0] d;
        d = 8'h3C;
        q_n.delete();
        send_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(0, d[i], 16);
        send_bit(0, d[4], 8);
        #1 reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        total++; if (dout_n !== 8'h00) begin bad++; $display("FAIL midreset_dout got=%h exp=00", dout_n); end
        total++; if ({done_n, pe_n, fe_n} !== 3'b000) begin bad++; $display("FAIL midreset_flags got=%b exp=000", {done_n, pe_n, fe_n}); end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        send_bit(0, 1'b1, 30);
        total++; if (q_n.size() !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", q_n.size()); end
        send_frame(0, d, 0, 1'b0, 1'b1, 16);
        send_bit(0, 1'b1, 20);
        total++; if (q_n.size() !== 1) begin bad++; $display("FAIL midreset_next_count got=%0d exp=1", q_n.size()); end
        r = (q_n.size() > 0) ? q_n.pop_front() : 'x;
        total++; if (r !== {8'h3C, 2'b00}) begin bad++; $display("FAIL midreset_next_frame got=%h exp=%h", r, {8'h3C, 2'b00}); end
    endtask

    task automatic test_random();
        rec_t exp_n[$];
        rec_t exp_p[$];
        rec_t r;
        logic [7:0] d;
        logic b, pbit;
        q_n.delete();
        q_p.delete();
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            b = 1'($urandom_range(0, 1));
            // Frame error: stop sampled low; frame still delivered.
            exp_n.push_back({d, 1'b0, ~b});
            send_frame(0, d, 0, 1'b0, b, b ? 16 : 12);
            send_bit(0, 1'b1, 24);
        end
        for (int k = 0; k < 6; k++) begin
            d    = 8'($urandom_range(0, 255));
            pbit = 1'($urandom_range(0, 1));
            // Even parity: total count of ones over data plus parity must be even.
            exp_p.push_back({d, 1'(($countones(d) + int'(pbit)) % 2), 1'b0});
            send_frame(1, d, 1, pbit, 1'b1, 16);
            send_bit(1, 1'b1, 24);
        end
        total++; if (q_n.size() !== 6) begin bad++; $display("FAIL rand_n_count got=%0d exp=6", q_n.size()); end
        total++; if (q_p.size() !== 6) begin bad++; $display("FAIL rand_p_count got=%0d exp=6", q_p.size()); end
        for (int k = 0; k < 6; k++) begin
            r = (q_n.size() > 0) ? q_n.pop_front() : 'x;
            total++; if (r !== exp_n[k]) begin bad++; $display("FAIL rand_n_frame%0d got=%h exp=%h", k, r, exp_n[k]); end
            r = (q_p.size() > 0) ? q_p.pop_front() : 'x;
            total++; if (r !== exp_p[k]) begin bad++; $display("FAIL rand_p_frame%0d got=%h exp=%h", k, r, exp_p[k]); end
        end
    endtask

    task automatic test_back_to_back();
        rec_t r;
        q_n.delete();
        long_pulse = 0;
        @(negedge clk);
        tick_tie = 1'b1;
        send_frame(0, 8'h00, 0, 1'b0, 1'b1, 16);
        send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 16);
        send_bit(0, 1'b1, 40);
        @(negedge clk);
        tick_tie = 1'b0;
        total++; if (q_n.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", q_n.size()); end
        r = (q_n.size() > 0) ? q_n.pop_front() : 'x;
        total++; if (r !== {8'h00, 2'b00}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", r, {8'h00, 2'b00}); end
        r = (q_n.size() > 0) ? q_n.pop_front() : 'x;
        total++; if (r !== {8'hFF, 2'b00}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", r, {8'hFF, 2'b00}); end
        total++; if (long_pulse !== 0) begin bad++; $display("FAIL done_pulse_width got=%0d exp=0", long_pulse); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_parity();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
